ulpi_reg_ctrl: RTL and testbench

Link-side ULPI controller for the DECA board's USB3300-class PHY; it sits between the SoC's USB register peripheral and the top-level `USB_DATA` / `USB_STP` / `USB_DIR` / `USB_NXT` pads. It converts single register-access requests into ULPI TX CMD sequences. It also decodes PHY-driven RX CMD bytes and receive data while the PHY owns the bus. The top level drives the pad when `USB_DIR`=0 and tri-states it otherwise, so this block only supplies `o_ulpi_data` and `o_ulpi_stp`.

---
 rtl/ulpi_pkg.sv | 30 +++
 rtl/ulpi_rx_decode.sv | 71 +++++++
 rtl/ulpi_reg_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_ulpi_reg_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ulpi_pkg.sv
// Shared constants, FSM state type and RX CMD field layout for the ULPI
// register-access controller.
package ulpi_pkg;

   // TX CMD prefixes and the idle bus value
   localparam logic [1:0] ULPI_REGW = 2'b10;
   localparam logic [1:0] ULPI_REGR = 2'b11;
   localparam logic [7:0] ULPI_NOOP = 8'h00;

   // Register-access sequencer states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_WDATA,
      ST_STP,
      ST_RTURN,
      ST_RDATA
   } state_e;

   // RX CMD byte layout: each field is two bits wide
   localparam int RXCMD_LS_LSB   = 0;
   localparam int RXCMD_VBUS_LSB = 2;
   localparam int RXCMD_EVT_LSB  = 4;

   // Immediate-address register TX CMD byte
   function automatic logic [7:0] tx_cmd(input logic we, input logic [5:0] addr);
      return {(we ? ULPI_REGW : ULPI_REGR), addr};
   endfunction

endpackage

// File: rtl/ulpi_rx_decode.sv
// Bus-direction tracking and PHY-to-link decode: turnaround detection,
// RX CMD status latch and receive-byte capture.
module ulpi_rx_decode
   import ulpi_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_ulpi_dir,
   input  logic       i_ulpi_nxt,
   input  logic [7:0] i_ulpi_data,
   input  logic       i_rdata_phase,
   output logic       o_dir_q,
   output logic       o_turnaround,
   output logic [1:0] o_linestate,
   output logic [1:0] o_vbus_state,
   output logic [1:0] o_rx_event,
   output logic       o_rx_cmd_valid,
   output logic [7:0] o_rx_data,
   output logic       o_rx_data_valid
);

   logic       dir_q;
   logic [1:0] linestate_q;
   logic [1:0] vbus_state_q;
   logic [1:0] rx_event_q;
   logic       rx_cmd_valid_q;
   logic [7:0] rx_data_q;
   logic       rx_data_valid_q;
   logic       phy_owns_bus;

   // PHY has held the bus for at least one full cycle, so the data is real
   assign phy_owns_bus = i_ulpi_dir & dir_q;
   assign o_turnaround = i_ulpi_dir ^ dir_q;

   // Track direction, latch RX CMD status and capture receive bytes
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         dir_q           <= 1'b1;
         linestate_q     <= 2'b00;
         vbus_state_q    <= 2'b00;
         rx_event_q      <= 2'b00;
         rx_cmd_valid_q  <= 1'b0;
         rx_data_q       <= 8'h00;
         rx_data_valid_q <= 1'b0;
      end else begin
         dir_q           <= i_ulpi_dir;
         rx_cmd_valid_q  <= 1'b0;
         rx_data_valid_q <= 1'b0;
         // A register-read data byte also arrives with nxt low; it is not status
         if (phy_owns_bus && !i_ulpi_nxt && !i_rdata_phase) begin
            linestate_q    <= i_ulpi_data[RXCMD_LS_LSB +: 2];
            vbus_state_q   <= i_ulpi_data[RXCMD_VBUS_LSB +: 2];
            rx_event_q     <= i_ulpi_data[RXCMD_EVT_LSB +: 2];
            rx_cmd_valid_q <= 1'b1;
         end
         if (phy_owns_bus && i_ulpi_nxt) begin
            rx_data_q       <= i_ulpi_data;
            rx_data_valid_q <= 1'b1;
         end
      end
   end

   assign o_dir_q         = dir_q;
   assign o_linestate     = linestate_q;
   assign o_vbus_state    = vbus_state_q;
   assign o_rx_event      = rx_event_q;
   assign o_rx_cmd_valid  = rx_cmd_valid_q;
   assign o_rx_data       = rx_data_q;
   assign o_rx_data_valid = rx_data_valid_q;

endmodule

// File: rtl/ulpi_reg_ctrl.sv
// ULPI link-side register-access controller: turns single read/write
// requests into TX CMD sequences and exposes decoded PHY status.
module ulpi_reg_ctrl
   import ulpi_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
)
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_req,
   input  logic       i_we,
   input  logic [5:0] i_addr,
   input  logic [7:0] i_wdata,
   output logic       o_ack,
   output logic       o_err,
   output logic [7:0] o_rdata,
   output logic       o_busy,
   input  logic       i_ulpi_dir,
   input  logic       i_ulpi_nxt,
   input  logic [7:0] i_ulpi_data,
   output logic [7:0] o_ulpi_data,
   output logic       o_ulpi_stp,
   output logic [1:0] o_linestate,
   output logic [1:0] o_vbus_state,
   output logic [1:0] o_rx_event,
   output logic       o_rx_cmd_valid,
   output logic [7:0] o_rx_data,
   output logic       o_rx_data_valid
);

   // Last stalled count before the timeout fires on the following edge
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_e     state_q;
   logic [7:0] tmo_q;
   logic [7:0] data_q;
   logic [7:0] rdata_q;
   logic       stp_q;
   logic       ack_q;
   logic       err_q;
   logic       busy_q;
   logic       dir_q;
   logic       turnaround;
   logic       tmo_hit;

   assign tmo_hit = (tmo_q == TMO_LAST);

   ulpi_rx_decode u_rx_decode (
      .i_clk           (i_clk),
      .i_rst_n         (i_rst_n),
      .i_ulpi_dir      (i_ulpi_dir),
      .i_ulpi_nxt      (i_ulpi_nxt),
      .i_ulpi_data     (i_ulpi_data),
      .i_rdata_phase   (state_q == ST_RDATA),
      .o_dir_q         (dir_q),
      .o_turnaround    (turnaround),
      .o_linestate     (o_linestate),
      .o_vbus_state    (o_vbus_state),
      .o_rx_event      (o_rx_event),
      .o_rx_cmd_valid  (o_rx_cmd_valid),
      .o_rx_data       (o_rx_data),
      .o_rx_data_valid (o_rx_data_valid)
   );

   // Register-access sequencer with registered bus drive and handshake
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         tmo_q   <= 8'h00;
         data_q  <= ULPI_NOOP;
         rdata_q <= 8'h00;
         stp_q   <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         stp_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               data_q <= ULPI_NOOP;
               busy_q <= 1'b0;
               // Skip the ack cycle: the requester has not yet dropped i_req
               if (i_req && !i_ulpi_dir && !dir_q && !ack_q) begin
                  state_q <= ST_CMD;
                  data_q  <= tx_cmd(i_we, i_addr);
                  tmo_q   <= 8'h00;
                  busy_q  <= 1'b1;
               end
            end
            ST_CMD: begin
               if (i_ulpi_dir) begin
                  state_q <= ST_IDLE;
                  data_q  <= ULPI_NOOP;
                  busy_q  <= 1'b0;
               end else if (i_ulpi_nxt) begin
                  tmo_q <= 8'h00;
                  if (i_we) begin
                     state_q <= ST_WDATA;
                     data_q  <= i_wdata;
                  end else begin
                     state_q <= ST_RTURN;
                     data_q  <= ULPI_NOOP;
                  end
               end else if (tmo_hit) begin
                  state_q <= ST_IDLE;
                  data_q  <= ULPI_NOOP;
                  ack_q   <= 1'b1;
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  tmo_q <= tmo_q + 8'd1;
               end
            end
            ST_WDATA: begin
               if (i_ulpi_dir) begin
                  state_q <= ST_IDLE;
                  data_q  <= ULPI_NOOP;
                  busy_q  <= 1'b0;
               end else if (i_ulpi_nxt) begin
                  state_q <= ST_STP;
                  data_q  <= ULPI_NOOP;
                  stp_q   <= 1'b1;
                  ack_q   <= 1'b1;
                  tmo_q   <= 8'h00;
               end else if (tmo_hit) begin
                  state_q <= ST_IDLE;
                  data_q  <= ULPI_NOOP;
                  ack_q   <= 1'b1;
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  tmo_q <= tmo_q + 8'd1;
               end
            end
            ST_STP: begin
               state_q <= ST_IDLE;
               data_q  <= ULPI_NOOP;
               busy_q  <= 1'b0;
            end
            ST_RTURN: begin
               // nxt during the turnaround means the PHY starts a receive instead
               if (i_ulpi_dir && i_ulpi_nxt) begin
                  state_q <= ST_IDLE;
                  data_q  <= ULPI_NOOP;
                  busy_q  <= 1'b0;
               end else if (i_ulpi_dir && turnaround) begin
                  state_q <= ST_RDATA;
                  tmo_q   <= 8'h00;
               end else if (tmo_hit) begin
                  state_q <= ST_IDLE;
                  data_q  <= ULPI_NOOP;
                  ack_q   <= 1'b1;
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  tmo_q <= tmo_q + 8'd1;
               end
            end
            ST_RDATA: begin
               state_q <= ST_IDLE;
               rdata_q <= i_ulpi_data;
               ack_q   <= 1'b1;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               data_q  <= ULPI_NOOP;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign o_ulpi_data = data_q;
   assign o_ulpi_stp  = stp_q;
   assign o_ack       = ack_q;
   assign o_err       = err_q;
   assign o_rdata     = rdata_q;
   assign o_busy      = busy_q;

endmodule

// File: tb/tb_ulpi_reg_ctrl.sv
// Directed bench for ulpi_reg_ctrl with a transaction-level reference model.
module tb_ulpi_reg_ctrl;

   localparam int TMO = 255;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       req   = 1'b0;
   logic       we    = 1'b0;
   logic [5:0] addr  = 6'h00;
   logic [7:0] wdata = 8'h00;
   logic       pdir  = 1'b0;
   logic       pnxt  = 1'b0;
   logic [7:0] pdata = 8'h00;

   logic       o_ack, o_err, o_busy, o_ulpi_stp, o_rx_cmd_valid, o_rx_data_valid;
   logic [7:0] o_rdata, o_ulpi_data, o_rx_data;
   logic [1:0] o_linestate, o_vbus_state, o_rx_event;

   ulpi_reg_ctrl dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_req           (req),
      .i_we            (we),
      .i_addr          (addr),
      .i_wdata         (wdata),
      .o_ack           (o_ack),
      .o_err           (o_err),
      .o_rdata         (o_rdata),
      .o_busy          (o_busy),
      .i_ulpi_dir      (pdir),
      .i_ulpi_nxt      (pnxt),
      .i_ulpi_data     (pdata),
      .o_ulpi_data     (o_ulpi_data),
      .o_ulpi_stp      (o_ulpi_stp),
      .o_linestate     (o_linestate),
      .o_vbus_state    (o_vbus_state),
      .o_rx_event      (o_rx_event),
      .o_rx_cmd_valid  (o_rx_cmd_valid),
      .o_rx_data       (o_rx_data),
      .o_rx_data_valid (o_rx_data_valid)
   );

   always #5 clk = ~clk;

   // ---------------- reference model (transaction level) ----------------
   // Bytes still to be handed to the PHY, head is the one on the bus.
   logic [7:0] tx_q[$];
   logic       m_dir = 1'b1, m_busy = 1'b0, m_write = 1'b0;
   logic       m_stp = 1'b0, m_rd = 1'b0, m_ack_prev = 1'b0;
   int         m_stall = 0;
   logic       e_ack = 0, e_err = 0, e_busy = 0, e_stp = 0, e_rxcv = 0, e_rxdv = 0;
   logic [7:0] e_rdata = 0, e_data = 0, e_rxd = 0;
   logic [1:0] e_ls = 0, e_vb = 0, e_ev = 0;

   task automatic model_give_up(input logic timed_out);
      tx_q.delete();
      m_busy = 1'b0;
      e_ack  = timed_out;
      e_err  = timed_out;
   endtask

   task automatic model_stall();
      m_stall++;
      if (m_stall == TMO) model_give_up(1'b1);
      else if (tx_q.size() > 0) e_data = tx_q[0];
   endtask

   task automatic model_step();
      logic turn;
      if (!rst_n) begin
         tx_q.delete();
         m_dir = 1'b1; m_busy = 1'b0; m_stp = 1'b0; m_rd = 1'b0;
         m_ack_prev = 1'b0; m_stall = 0;
         e_ack = 0; e_err = 0; e_busy = 0; e_stp = 0; e_rxcv = 0; e_rxdv = 0;
         e_rdata = 0; e_data = 0; e_rxd = 0; e_ls = 0; e_vb = 0; e_ev = 0;
         return;
      end
      turn   = (pdir != m_dir);
      // PHY-owned traffic: status bytes have nxt low, receive bytes nxt high
      e_rxcv = pdir && m_dir && !pnxt && !m_rd;
      if (e_rxcv) begin
         e_ls = pdata[1:0];
         e_vb = pdata[3:2];
         e_ev = pdata[5:4];
      end
      e_rxdv = pdir && m_dir && pnxt;
      if (e_rxdv) e_rxd = pdata;
      e_ack = 0; e_err = 0; e_stp = 0; e_data = 8'h00;
      if (!m_busy) begin
         if (req && !pdir && !m_dir && !m_ack_prev) begin
            m_busy  = 1'b1;
            m_write = we;
            m_stall = 0;
            tx_q.delete();
            tx_q.push_back({(we ? 2'b10 : 2'b11), addr});
            if (we) tx_q.push_back(wdata);
            e_data = tx_q[0];
         end
      end else if (m_stp) begin
         m_stp  = 1'b0;
         m_busy = 1'b0;
      end else if (m_rd) begin
         m_rd    = 1'b0;
         m_busy  = 1'b0;
         e_ack   = 1'b1;
         e_rdata = pdata;
      end else if (tx_q.size() > 0) begin
         if (pdir) model_give_up(1'b0);
         else if (pnxt) begin
            void'(tx_q.pop_front());
            m_stall = 0;
            if (tx_q.size() > 0) e_data = tx_q[0];
            else if (m_write) begin
               m_stp = 1'b1; e_stp = 1'b1; e_ack = 1'b1;
            end
         end else model_stall();
      end else begin
         // read command accepted, waiting for the PHY to take the bus
         if (pdir && pnxt) model_give_up(1'b0);
         else if (pdir && turn) begin
            m_rd    = 1'b1;
            m_stall = 0;
         end else model_stall();
      end
      m_ack_prev = e_ack;
      m_dir      = pdir;
      e_busy     = m_busy;
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         model_step();
      end
   end

   // ---------------- checking ----------------
   int         n_tests = 0;
   int         n_fail  = 0;
   int         n_ack = 0, n_rxc = 0, n_rxd = 0;
   logic       ack_prev = 1'b0;
   logic [7:0] seen[$];

   function automatic logic [35:0] dut_vec();
      return {o_ack, o_err, o_rdata, o_busy, o_ulpi_data, o_ulpi_stp, o_linestate,
              o_vbus_state, o_rx_event, o_rx_cmd_valid, o_rx_data, o_rx_data_valid};
   endfunction

   function automatic logic [35:0] exp_vec();
      return {e_ack, e_err, e_rdata, e_busy, e_data, e_stp, e_ls,
              e_vb, e_ev, e_rxcv, e_rxd, e_rxdv};
   endfunction

   task automatic check(input string name, input logic [35:0] act, input logic [35:0] want);
      n_tests++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, want);
      end
   endtask

   task automatic compare();
      check("model_compare", dut_vec(), exp_vec());
      n_tests++;
      if ((o_ack && ack_prev) || (o_rx_cmd_valid && o_rx_data_valid)) begin
         n_fail++;
         $display("FAIL pulse_rules t=%0t actual=ack%0d/%0d rxv%0d%0d required=no_overlap",
                  $time, ack_prev, o_ack, o_rx_cmd_valid, o_rx_data_valid);
      end
      ack_prev = o_ack;
      if (o_ack) n_ack++;
      if (o_rx_cmd_valid) n_rxc++;
      if (o_rx_data_valid) n_rxd++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic set_phy(input logic d, input logic n, input logic [7:0] v);
      pdir  = d;
      pnxt  = n;
      pdata = v;
   endtask

   // PHY accepts every non-NOOP byte on its first cycle
   task automatic run_until_ack(output int cycles);
      cycles = 0;
      seen.delete();
      while (!o_ack && cycles < 40) begin
         set_phy(1'b0, (o_ulpi_data != 8'h00), 8'h00);
         tick();
         cycles++;
         if (o_ulpi_data != 8'h00) seen.push_back(o_ulpi_data);
      end
   endtask

   initial begin
      int n;
      int a0, c0, d0;

      repeat (3) tick();
      check("reset_state", dut_vec(), 36'h0);
      rst_n = 1'b1;
      repeat (3) tick();

      // Write 0x45 to register 0x04
      req = 1'b1; we = 1'b1; addr = 6'h04; wdata = 8'h45;
      run_until_ack(n);
      check("wr_ack", 36'(o_ack), 36'h1);
      check("wr_err", 36'(o_err), 36'h0);
      check("wr_stp", 36'({o_ulpi_stp, o_ulpi_data}), 36'h100);
      check("wr_bytes", 36'(seen.size()), 36'h2);
      check("wr_cmd_byte", 36'(seen[0]), 36'h84);
      check("wr_data_byte", 36'(seen[1]), 36'h45);
      check("wr_cycles", 36'(n + 1), 36'h4);
      $display("[TB] write addr=04 data=45 ack in cycle %0d err=%0d", n + 1, o_err);
      req = 1'b0;
      repeat (2) tick();

      // Read register 0x00, PHY returns 0x24
      req = 1'b1; we = 1'b0; addr = 6'h00;
      tick();
      check("rd_cmd_byte", 36'(o_ulpi_data), 36'hC0);
      set_phy(1'b0, 1'b1, 8'h00); tick();
      set_phy(1'b1, 1'b0, 8'h00); tick();
      set_phy(1'b1, 1'b0, 8'h24); tick();
      check("rd_ack", 36'({o_ack, o_err}), 36'h2);
      check("rd_data", 36'(o_rdata), 36'h24);
      $display("[TB] read addr=00 rdata=%02h", o_rdata);
      req = 1'b0; set_phy(1'b0, 1'b0, 8'h00);
      repeat (3) tick();

      // Write aborted by an RX CMD, then retried
      a0 = n_ack; c0 = n_rxc;
      req = 1'b1; we = 1'b1; addr = 6'h04; wdata = 8'h45;
      tick();
      check("ab_cmd_byte", 36'(o_ulpi_data), 36'h84);
      set_phy(1'b1, 1'b0, 8'h00); tick();
      check("ab_dropped", 36'({o_ack, o_busy, o_ulpi_data}), 36'h0);
      set_phy(1'b1, 1'b0, 8'h0D); tick();
      check("ab_status", 36'({o_rx_cmd_valid, o_linestate, o_vbus_state, o_rx_event}), 36'h5C);
      run_until_ack(n);
      check("ab_retry_ack", 36'({o_ack, o_err, o_ulpi_stp}), 36'h5);
      req = 1'b0;
      repeat (3) tick();
      check("ab_ack_count", 36'(n_ack - a0), 36'h1);
      check("ab_rxcmd_count", 36'(n_rxc - c0), 36'h1);
      $display("[TB] aborted write retried, acks=%0d rxcmds=%0d", n_ack - a0, n_rxc - c0);

      // PHY never asserts nxt
      req = 1'b1; we = 1'b1; addr = 6'h04; wdata = 8'h45;
      set_phy(1'b0, 1'b0, 8'h00);
      tick();
      n = 0;
      while (!o_ack && n < TMO + 20) begin
         tick();
         n++;
      end
      check("tmo_cycles", 36'(n), 36'(TMO));
      check("tmo_ack_err", 36'({o_ack, o_err, o_ulpi_data}), 36'h300);
      $display("[TB] timeout write ack after %0d cycles err=%0d", n, o_err);
      req = 1'b0;
      tick();
      check("tmo_bus_idle", 36'({o_busy, o_ulpi_data}), 36'h0);

      // Receive burst
      c0 = n_rxc; d0 = n_rxd;
      set_phy(1'b1, 1'b0, 8'hAA); tick();
      set_phy(1'b1, 1'b1, 8'hC3); tick();
      check("rx_byte0", 36'({o_rx_data_valid, o_rx_data}), 36'h1C3);
      set_phy(1'b1, 1'b1, 8'h11); tick();
      check("rx_byte1", 36'({o_rx_data_valid, o_rx_data}), 36'h111);
      set_phy(1'b0, 1'b0, 8'h00); repeat (2) tick();
      check("rx_counts", 36'({8'(n_rxd - d0), 8'(n_rxc - c0)}), 36'h200);
      $display("[TB] receive burst bytes=%0d rxcmds=%0d", n_rxd - d0, n_rxc - c0);

      // Reset during WDATA
      a0 = n_ack;
      req = 1'b1; we = 1'b1; addr = 6'h04; wdata = 8'h45;
      tick();
      set_phy(1'b0, 1'b1, 8'h00); tick();
      check("rst_wdata_byte", 36'(o_ulpi_data), 36'h45);
      set_phy(1'b0, 1'b0, 8'h00);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async", dut_vec(), 36'h0);
      check("rst_model", dut_vec(), exp_vec());
      req = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (6) tick();
      check("rst_no_ack", 36'(n_ack - a0), 36'h0);
      $display("[TB] reset during write, acks after release=%0d", n_ack - a0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog t=%0t actual=running required=finished", $time);
      $fatal(1, "watchdog");
   end

endmodule
